// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state enum, access encodings and counter width.
package dmem_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_e;

  localparam logic DMEM_READ  = 1'b0;
  localparam logic DMEM_WRITE = 1'b1;

  localparam int DMEM_CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word RAM: synchronous write, combinational read.
// No reset; contents survive rst_n.
module dmem_array #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] widx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  assign rdata = mem[widx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, fixed wait states.
// Define DATA_MEM_ALIGN_CHECK_EN to fault misaligned accesses.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [DMEM_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : DMEM_CNT_W'(WAIT_CYCLES - 1);

  dmem_state_e state, state_nxt;

  logic [DMEM_CNT_W-1:0] cnt;
  logic                  lat_rw;
  logic                  lat_fault;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [31:0]           lat_wdata;

  logic                  accept;
  logic                  enter_resp;
  logic                  req_fault;
  logic                  cur_rw;
  logic                  cur_fault;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic [31:0]           cur_wdata;
  logic [31:0]           arr_rdata;
  logic                  arr_we;
  logic                  unused_addr;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign req_fault = (req_addr[1:0] != 2'b00);
`else
  assign req_fault = 1'b0;
`endif

  assign unused_addr =
    ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DMEM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state)
      DMEM_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        accept    = req_valid;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = DMEM_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt == '0) begin
          state_nxt  = DMEM_RESP;
          enter_resp = 1'b1;
        end
      end
      DMEM_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = DMEM_IDLE;
        end
      end
      default: state_nxt = DMEM_IDLE;
    endcase
  end

  // Zero wait states commit on the accept edge, before the latches load.
  always_comb begin
    if (state == DMEM_IDLE) begin
      cur_rw    = req_rw;
      cur_fault = req_fault;
      cur_idx   = req_addr[DEPTH_LOG2+1:2];
      cur_wdata = req_wdata;
    end else begin
      cur_rw    = lat_rw;
      cur_fault = lat_fault;
      cur_idx   = lat_idx;
      cur_wdata = lat_wdata;
    end
  end

  assign arr_we = enter_resp && (cur_rw == DMEM_WRITE) && !cur_fault;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .widx (cur_idx),
    .wdata(cur_wdata),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_rw    <= DMEM_READ;
      lat_fault <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_rw    <= req_rw;
        lat_fault <= req_fault;
        lat_idx   <= req_addr[DEPTH_LOG2+1:2];
        lat_wdata <= req_wdata;
        cnt       <= CNT_INIT;
      end else if (state == DMEM_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        rsp_err <= cur_fault;
        if (cur_rw == DMEM_READ && !cur_fault) begin
          rsp_rdata <= arr_rdata;
        end else begin
          rsp_rdata <= '0;
        end
      end else if (state == DMEM_RESP && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule
